// File: rtl/mycpu_id_stage.sv
// Instruction-decode stage: holds one instruction, resolves operands
// through the ES/MS/WS bypass network and stalls on load-use hazards.
module mycpu_id_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fs_valid,
  input  logic [DATA_WIDTH-1:0] fs_inst,
  input  logic [DATA_WIDTH-1:0] fs_pc,
  output logic                  ds_allowin,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  es_fwd_valid,
  input  logic [ADDR_WIDTH-1:0] es_fwd_waddr,
  input  logic [DATA_WIDTH-1:0] es_fwd_wdata,
  input  logic                  es_is_load,
  input  logic                  ms_fwd_valid,
  input  logic [ADDR_WIDTH-1:0] ms_fwd_waddr,
  input  logic [DATA_WIDTH-1:0] ms_fwd_wdata,
  input  logic                  ws_wen,
  input  logic [ADDR_WIDTH-1:0] ws_waddr,
  input  logic [DATA_WIDTH-1:0] ws_wdata,
  input  logic                  es_allowin,
  input  logic                  flush,
  output logic                  ds_to_es_valid,
  output logic [DATA_WIDTH-1:0] ds_pc,
  output logic [DATA_WIDTH-1:0] ds_inst,
  output logic [DATA_WIDTH-1:0] ds_src1,
  output logic [DATA_WIDTH-1:0] ds_src2,
  output logic [ADDR_WIDTH-1:0] ds_dest
);

  logic                  ds_valid_q, ds_valid_d;
  logic [DATA_WIDTH-1:0] ds_inst_q, ds_inst_d;
  logic [DATA_WIDTH-1:0] ds_pc_q, ds_pc_d;
  logic                  ds_ready_go;
  logic                  es_hit1, es_hit2;
  logic [5:0]            opcode;

  function automatic logic [DATA_WIDTH-1:0] fwd(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] rf
  );
    if (a == '0)
      fwd = '0;
    else if (es_fwd_valid && es_fwd_waddr == a)
      fwd = es_fwd_wdata;
    else if (ms_fwd_valid && ms_fwd_waddr == a)
      fwd = ms_fwd_wdata;
    else if (ws_wen && ws_waddr == a)
      fwd = ws_wdata;
    else
      fwd = rf;
  endfunction

  assign opcode    = ds_inst_q[31:26];
  assign rf_raddr1 = ADDR_WIDTH'(ds_inst_q[25:21]);
  assign rf_raddr2 = ADDR_WIDTH'(ds_inst_q[20:16]);

  assign ds_src1 = fwd(rf_raddr1, rf_rdata1);
  assign ds_src2 = fwd(rf_raddr2, rf_rdata2);

  // A load still in ES has no data yet; r0 never creates a hazard.
  assign es_hit1 = (rf_raddr1 != '0) && (es_fwd_waddr == rf_raddr1);
  assign es_hit2 = (rf_raddr2 != '0) && (es_fwd_waddr == rf_raddr2);
  assign ds_ready_go =
    !(es_fwd_valid && es_is_load && (es_hit1 || es_hit2));

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;

  always_comb begin
    ds_dest = ADDR_WIDTH'(ds_inst_q[20:16]);
    if (opcode == 6'h00)
      ds_dest = ADDR_WIDTH'(ds_inst_q[15:11]);
    else if (opcode == 6'h03)
      ds_dest = ADDR_WIDTH'(31);
  end

  assign ds_pc   = ds_pc_q;
  assign ds_inst = ds_inst_q;

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_inst_d  = ds_inst_q;
    ds_pc_d    = ds_pc_q;
    if (flush)
      ds_valid_d = 1'b0;
    else if (ds_allowin)
      ds_valid_d = fs_valid;
    if (fs_valid && ds_allowin && !flush) begin
      ds_inst_d = fs_inst;
      ds_pc_d   = fs_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_valid_q <= 1'b0;
      ds_inst_q  <= '0;
      ds_pc_q    <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_inst_q  <= ds_inst_d;
      ds_pc_q    <= ds_pc_d;
    end
  end

endmodule

// File: tb/tb_mycpu_id_stage.sv
// Bench for mycpu_id_stage: directed scenarios plus random traffic
// compared against an abstract pipeline-slot model.
module tb_mycpu_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs_valid;
  logic [31:0] fs_inst, fs_pc;
  logic        ds_allowin;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        es_fwd_valid, es_is_load;
  logic [4:0]  es_fwd_waddr;
  logic [31:0] es_fwd_wdata;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_waddr;
  logic [31:0] ms_fwd_wdata;
  logic        ws_wen;
  logic [4:0]  ws_waddr;
  logic [31:0] ws_wdata;
  logic        es_allowin, flush;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc, ds_inst, ds_src1, ds_src2;
  logic [4:0]  ds_dest;

  int total = 0;
  int bad   = 0;

  // model of the single pipeline slot
  bit          m_valid;
  logic [31:0] m_inst, m_pc;

  always #5 clk = ~clk;

  assign rf_rdata1 = {16'hF00D, 11'b0, rf_raddr1};
  assign rf_rdata2 = {16'hBEEF, 11'b0, rf_raddr2};

  mycpu_id_stage dut (
    .clk(clk), .rst(rst),
    .fs_valid(fs_valid), .fs_inst(fs_inst), .fs_pc(fs_pc),
    .ds_allowin(ds_allowin),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .es_fwd_valid(es_fwd_valid), .es_fwd_waddr(es_fwd_waddr),
    .es_fwd_wdata(es_fwd_wdata), .es_is_load(es_is_load),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_waddr(ms_fwd_waddr),
    .ms_fwd_wdata(ms_fwd_wdata),
    .ws_wen(ws_wen), .ws_waddr(ws_waddr), .ws_wdata(ws_wdata),
    .es_allowin(es_allowin), .flush(flush),
    .ds_to_es_valid(ds_to_es_valid),
    .ds_pc(ds_pc), .ds_inst(ds_inst),
    .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_dest(ds_dest)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] a,
                                          input logic [31:0] rf);
    bit          v[3];
    logic [4:0]  wa[3];
    logic [31:0] wd[3];
    v  = '{es_fwd_valid, ms_fwd_valid, ws_wen};
    wa = '{es_fwd_waddr, ms_fwd_waddr, ws_waddr};
    wd = '{es_fwd_wdata, ms_fwd_wdata, ws_wdata};
    if (a == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (v[k] && wa[k] == a) return wd[k];
    return rf;
  endfunction

  function automatic bit ref_ready();
    logic [4:0] rs, rt;
    rs = f_rs(m_inst);
    rt = f_rt(m_inst);
    if (!(es_fwd_valid && es_is_load)) return 1;
    if (rs != 0 && es_fwd_waddr == rs) return 0;
    if (rt != 0 && es_fwd_waddr == rt) return 0;
    return 1;
  endfunction

  function automatic bit ref_allowin();
    return !m_valid || (ref_ready() && es_allowin);
  endfunction

  function automatic logic [4:0] ref_dest();
    case (m_inst[31:26])
      6'h00:   return m_inst[15:11];
      6'h03:   return 5'd31;
      default: return m_inst[20:16];
    endcase
  endfunction

  task automatic check_all();
    logic [4:0] rs, rt;
    rs = f_rs(m_inst);
    rt = f_rt(m_inst);
    chk("allowin", 32'(ds_allowin), 32'(ref_allowin()));
    chk("to_es", 32'(ds_to_es_valid),
        32'(m_valid && ref_ready() && !flush));
    chk("raddr1", 32'(rf_raddr1), 32'(rs));
    chk("raddr2", 32'(rf_raddr2), 32'(rt));
    chk("src1", ds_src1, ref_src(rs, {16'hF00D, 11'b0, rs}));
    chk("src2", ds_src2, ref_src(rt, {16'hBEEF, 11'b0, rt}));
    chk("dest", 32'(ds_dest), 32'(ref_dest()));
    chk("pc", ds_pc, m_pc);
    chk("inst", ds_inst, m_inst);
  endtask

  task automatic settle();
    #4;
    check_all();
  endtask

  task automatic adv();
    bit al;
    @(posedge clk);
    al = ref_allowin();
    if (fs_valid && al && !flush) begin
      m_inst = fs_inst;
      m_pc   = fs_pc;
    end
    if (flush) m_valid = 0;
    else if (al) m_valid = fs_valid;
    #1;
  endtask

  task automatic idle_inputs();
    fs_valid = 0; fs_inst = 0; fs_pc = 0;
    es_fwd_valid = 0; es_fwd_waddr = 0; es_fwd_wdata = 0;
    es_is_load = 0;
    ms_fwd_valid = 0; ms_fwd_waddr = 0; ms_fwd_wdata = 0;
    ws_wen = 0; ws_waddr = 0; ws_wdata = 0;
    es_allowin = 1; flush = 0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic [4:0] rd);
    return {op, rs, rt, rd, 11'h05A};
  endfunction

  // capture one instruction and then hold it in the stage
  task automatic load_inst(input logic [31:0] i, input logic [31:0] pc);
    fs_valid = 1; fs_inst = i; fs_pc = pc; es_allowin = 0;
    settle(); adv();
    fs_valid = 0;
  endtask

  logic [31:0] ia, ib, ic;

  initial begin
    idle_inputs();
    rst = 0;
    m_valid = 0; m_inst = 0; m_pc = 0;
    @(posedge clk); #1;
    settle();
    chk("rst_allowin", 32'(ds_allowin), 32'd1);
    chk("rst_to_es", 32'(ds_to_es_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1;

    // back-to-back flow
    fs_valid = 1; fs_pc = 32'h100; fs_inst = mk(6'h00, 1, 2, 3);
    settle(); adv();
    for (int k = 1; k <= 3; k++) begin
      fs_pc = 32'h100 + 32'(4 * k);
      fs_valid = (k < 3);
      settle();
      chk("b2b_valid", 32'(ds_to_es_valid), 32'd1);
      chk("b2b_pc", ds_pc, 32'h100 + 32'(4 * (k - 1)));
      adv();
    end

    // bypass priority
    load_inst(mk(6'h00, 8, 9, 10), 32'h200);
    es_fwd_waddr = 8; es_fwd_wdata = 32'h11;
    ms_fwd_waddr = 8; ms_fwd_wdata = 32'h22;
    ws_waddr = 8;     ws_wdata = 32'h33;
    es_fwd_valid = 1; ms_fwd_valid = 1; ws_wen = 1;
    settle(); chk("byp_es", ds_src1, 32'h11); adv();
    es_fwd_valid = 0;
    settle(); chk("byp_ms", ds_src1, 32'h22); adv();
    ms_fwd_valid = 0;
    settle(); chk("byp_ws", ds_src1, 32'h33); adv();
    ws_wen = 0;
    settle(); chk("byp_rf", ds_src1, 32'hF00D0008); adv();

    // load-use stall then MS bypass
    es_allowin = 1;
    es_fwd_valid = 1; es_fwd_waddr = 9; es_is_load = 1;
    settle();
    chk("lu_allowin", 32'(ds_allowin), 32'd0);
    chk("lu_to_es", 32'(ds_to_es_valid), 32'd0);
    adv();
    es_fwd_valid = 0; es_is_load = 0;
    ms_fwd_valid = 1; ms_fwd_waddr = 9; ms_fwd_wdata = 32'hABCD;
    settle();
    chk("lu_src2", ds_src2, 32'hABCD);
    chk("lu_go", 32'(ds_to_es_valid), 32'd1);
    adv();
    ms_fwd_valid = 0;

    // register 0 never bypasses or stalls
    load_inst(mk(6'h00, 0, 9, 4), 32'h300);
    es_allowin = 1;
    es_fwd_valid = 1; es_fwd_waddr = 0; es_fwd_wdata = 32'hFFFF;
    es_is_load = 1;
    settle();
    chk("r0_src1", ds_src1, 32'd0);
    chk("r0_go", 32'(ds_to_es_valid), 32'd1);
    adv();
    idle_inputs();

    // flush wins over capture
    ia = mk(6'h23, 3, 4, 5);
    load_inst(ia, 32'h400);
    fs_valid = 1; fs_inst = mk(6'h03, 6, 7, 8); fs_pc = 32'h404;
    flush = 1;
    settle(); adv();
    flush = 0; fs_valid = 0;
    settle();
    chk("fl_to_es", 32'(ds_to_es_valid), 32'd0);
    chk("fl_inst", ds_inst, ia);
    adv();

    // backpressure
    ib = mk(6'h03, 2, 3, 4);
    load_inst(ib, 32'h500);
    fs_valid = 1; fs_inst = mk(6'h00, 7, 7, 7); fs_pc = 32'h600;
    es_allowin = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("bp_pc", ds_pc, 32'h500);
      chk("bp_inst", ds_inst, ib);
      chk("bp_dest", 32'(ds_dest), 32'd31);
      chk("bp_allowin", 32'(ds_allowin), 32'd0);
      adv();
    end
    es_allowin = 1; fs_valid = 0;
    settle();
    chk("bp_go", 32'(ds_to_es_valid), 32'd1);
    adv();

    // reset during a stall
    ic = mk(6'h00, 5, 6, 7);
    load_inst(ic, 32'h700);
    es_fwd_valid = 1; es_fwd_waddr = 5; es_is_load = 1;
    es_allowin = 1;
    settle(); adv();
    rst = 0;
    m_valid = 0; m_inst = 0; m_pc = 0;
    #1;
    chk("rs_allowin", 32'(ds_allowin), 32'd1);
    chk("rs_inst", ds_inst, 32'd0);
    check_all();
    @(posedge clk); #1;
    rst = 1;
    idle_inputs();
    fs_valid = 1; fs_inst = ic; fs_pc = 32'h800;
    settle(); adv();
    fs_valid = 0;
    settle();
    chk("rs_cap_pc", ds_pc, 32'h800);
    chk("rs_cap_v", 32'(ds_to_es_valid), 32'd1);
    adv();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 2))
        0: op = 6'h00;
        1: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      fs_valid = ($urandom_range(0, 9) < 7);
      fs_inst = mk(op, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom));
      fs_pc = $urandom;
      es_fwd_valid = $urandom_range(0, 1) == 1;
      es_fwd_waddr = 5'($urandom_range(0, 3));
      es_fwd_wdata = $urandom;
      es_is_load = ($urandom_range(0, 9) < 3);
      ms_fwd_valid = $urandom_range(0, 1) == 1;
      ms_fwd_waddr = 5'($urandom_range(0, 3));
      ms_fwd_wdata = $urandom;
      ws_wen = $urandom_range(0, 1) == 1;
      ws_waddr = 5'($urandom_range(0, 3));
      ws_wdata = $urandom;
      es_allowin = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 9) == 0);
      settle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mycpu_id_stage.md
MYCPU_ID_STAGE -- requirements
Module: myCPU_id_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath and instruction width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register-number width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port fs_valid  input  1  upstream instruction valid.
REQ-006 SHALL have ports fs_inst, fs_pc  input  DATA_WIDTH each  upstream instruction word and its PC.
REQ-007 SHALL have port ds_allowin  output  1  stage can accept an instruction this cycle.
REQ-008 SHALL have ports rf_raddr1, rf_raddr2  output  ADDR_WIDTH each  register-file read addresses.
REQ-009 SHALL have ports rf_rdata1, rf_rdata2  input  DATA_WIDTH each  combinational register-file read data.
REQ-010 SHALL have ports es_fwd_valid (1), es_fwd_waddr (ADDR_WIDTH), es_fwd_wdata (DATA_WIDTH), es_is_load (1)  input  EXE-stage bypass.
REQ-011 SHALL have ports ms_fwd_valid (1), ms_fwd_waddr (ADDR_WIDTH), ms_fwd_wdata (DATA_WIDTH)  input  MEM-stage bypass.
REQ-012 SHALL have ports ws_wen (1), ws_waddr (ADDR_WIDTH), ws_wdata (DATA_WIDTH)  input  WB write, the same signals that drive the register-file write port.
REQ-013 SHALL have port es_allowin  input  1  downstream can accept.
REQ-014 SHALL have port flush  input  1  discard the held instruction (taken branch or exception).
REQ-015 SHALL have port ds_to_es_valid  output  1  downstream handoff valid.
REQ-016 SHALL have ports ds_pc, ds_inst, ds_src1, ds_src2 (DATA_WIDTH each) and ds_dest (ADDR_WIDTH)  output  payload to EXE.

Function
REQ-017 SHALL hold ds_valid, ds_inst and ds_pc in stage registers.
REQ-018 SHALL drive rf_raddr1 = ds_inst[25:21] (rs) and rf_raddr2 = ds_inst[20:16] (rt), combinationally from the held instruction.
REQ-019 SHALL select ds_src1 from the first matching source in priority order: ES, then MS, then WS, then rf_rdata1; ds_src2 uses the same order with rf_rdata2.
- A source matches when its valid/wen is 1 and its waddr equals the read address.
REQ-020 SHALL force a source operand to 0 when its read address is 0, with no bypass applied.
REQ-021 SHALL treat an ES match on a nonzero address with es_is_load=1 as load-use: ds_ready_go = 0; otherwise ds_ready_go = 1.
REQ-022 SHALL drive ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
REQ-023 SHALL drive ds_to_es_valid = ds_valid & ds_ready_go & !flush.
REQ-024 SHALL update ds_valid at each clock edge by the first matching case:
- flush=1: ds_valid <= 0.
- else ds_allowin=1: ds_valid <= fs_valid.
- else: ds_valid holds.
REQ-025 SHALL load ds_inst and ds_pc only when fs_valid & ds_allowin & !flush; otherwise they hold.
REQ-026 SHALL, while stalled, keep ds_inst, ds_pc and ds_dest stable and re-evaluate ds_src1/ds_src2 every cycle, so the load result bypasses once the load leaves ES.
REQ-027 SHALL compute ds_dest as:
- opcode ds_inst[31:26] = 6'h00: ds_inst[15:11];
- opcode = 6'h03 (JAL): 5'd31;
- otherwise: ds_inst[20:16].
REQ-028 SHALL make flush win over a simultaneous fs_valid: the instruction is not captured and ds_valid is 0 next cycle.
REQ-029 SHALL give ds_to_es_valid zero latency and give capture one cycle from fs_valid & ds_allowin, with no bubble under back-to-back flow.

Reset
REQ-030 SHALL, while rst=0, asynchronously clear ds_valid, ds_inst and ds_pc to 0; therefore ds_to_es_valid=0, ds_allowin=1, rf_raddr1/2=0, ds_src1/2=0, ds_dest=0.
REQ-031 SHALL, when rst is asserted mid-stall, drop the held instruction; after rst releases, the first fs_valid is captured on the next edge.

Verification
REQ-032 Back-to-back: fs_valid=1 and es_allowin=1 for 3 cycles, PCs 0x100/0x104/0x108 -> ds_to_es_valid=1 on 3 consecutive cycles with matching PCs.
REQ-033 Bypass priority: rs=8; ES, MS and WS all match with data 0x11/0x22/0x33 -> ds_src1=0x11; ES invalid -> 0x22; only WS -> 0x33; none -> rf_rdata1.
REQ-034 Load-use: es_is_load=1 on waddr 9, rt=9 -> ds_allowin=0 and ds_to_es_valid=0 for 1 cycle; next cycle MS forwards 0xABCD -> ds_src2=0xABCD, handoff occurs.
REQ-035 Register 0: rs=0 while ES writes waddr 0 with 0xFFFF -> ds_src1=0 and no stall.
REQ-036 Flush plus capture: flush=1 and fs_valid=1 on the same edge -> ds_valid=0 next cycle and ds_inst unchanged.
REQ-037 Backpressure: es_allowin=0 for 4 cycles -> ds_pc/ds_inst/ds_dest stable, ds_allowin=0; release -> handoff on that cycle.
